vram_arbiter: RTL and testbench

Shares the single-port video RAM between CPU framebuffer writes and VGA pixel fetches. CPU writes are buffered in a small FIFO so the CPU never waits on display timing. VGA reads get priority, with a starvation guard for pending CPU writes. Sits between cpu, vga and the VRAM macro in top, replacing the direct addr_bus/vga_we/ram_in wiring.

---
 rtl/vram_arbiter_pkg.sv | 15 +
 rtl/vram_arbiter_if.sv | 33 +++
 rtl/vram_arbiter_wr_fifo.sv | 51 +++++
 rtl/vram_arbiter.sv | 117 +++++++++++
 tb/tb_vram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default sizes for the VRAM arbiter: FSM state encoding and bus widths.
`timescale 1ns/1ps
package vram_arbiter_pkg;
  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } arb_state_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// Bundles the CPU write port, VGA read port and VRAM macro port of the arbiter.
`timescale 1ns/1ps
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = vram_arbiter_pkg::DATA_W_DEF
);
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              ovf;

  // Arbiter side
  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_rdata,
    output cpu_busy, vga_ack, vga_rdata, ram_addr, ram_wdata, ram_we, ram_re, ovf
  );

  // Environment side: CPU, VGA and the VRAM macro
  modport master (
    output cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_rdata,
    input  cpu_busy, vga_ack, vga_rdata, ram_addr, ram_wdata, ram_we, ram_re, ovf
  );
endinterface

// File: rtl/vram_arbiter_wr_fifo.sv
// Small synchronous FIFO buffering CPU framebuffer writes; head is visible without a pop.
`timescale 1ns/1ps
module vram_wr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads first, buffered CPU writes, starvation guard.
// Define VRAM_ARB_OVF_EN to build the sticky overflow flag on dropped CPU writes.
`timescale 1ns/1ps
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   starve_reg, starve_next;
  logic               rd_grant, wr_grant;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  ram_addr_reg;
  logic [DATA_W-1:0]  ram_wdata_reg;
  logic               ram_we_reg, ram_re_reg;
  logic               vga_ack_reg;
  logic [DATA_W-1:0]  vga_rdata_reg;

  vram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cpu_we),
    .push_data ({bus.cpu_addr, bus.cpu_wdata}),
    .pop       (state_reg == WR),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    rd_grant    = 1'b0;
    wr_grant    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && starve_reg == STARVE_MAX) begin
          wr_grant   = 1'b1;
          state_next = WR;
        end else if (bus.vga_req) begin
          rd_grant   = 1'b1;
          state_next = RD_ISSUE;
        end else if (!fifo_empty) begin
          wr_grant   = 1'b1;
          state_next = WR;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT:  state_next = IDLE;
      WR:       state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // Only reads granted while writes wait count towards forcing a write.
    if (wr_grant || fifo_empty) begin
      starve_next = '0;
    end else if (rd_grant && starve_reg != STARVE_MAX) begin
      starve_next = starve_reg + CNT_W'(1);
    end
  end

  // RAM controls are registered at grant time so they line up with RD_ISSUE / WR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      ram_we_reg    <= 1'b0;
      ram_re_reg    <= 1'b0;
      vga_ack_reg   <= 1'b0;
      vga_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      starve_reg  <= starve_next;
      ram_re_reg  <= rd_grant;
      ram_we_reg  <= wr_grant;
      vga_ack_reg <= (state_reg == RD_WAIT);
      if (rd_grant) ram_addr_reg <= bus.vga_addr;
      if (wr_grant) {ram_addr_reg, ram_wdata_reg} <= fifo_head;
      if (state_reg == RD_WAIT) vga_rdata_reg <= bus.ram_rdata;
    end
  end

  assign bus.cpu_busy  = fifo_full;
  assign bus.ram_addr  = ram_addr_reg;
  assign bus.ram_wdata = ram_wdata_reg;
  assign bus.ram_we    = ram_we_reg;
  assign bus.ram_re    = ram_re_reg;
  assign bus.vga_ack   = vga_ack_reg;
  assign bus.vga_rdata = vga_rdata_reg;

`ifdef VRAM_ARB_OVF_EN
  logic ovf_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_reg <= 1'b0;
    else if (bus.cpu_we && fifo_full) ovf_reg <= 1'b1;
  end
  assign bus.ovf = ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, directed corner cases, random run vs. model.
`timescale 1ns/1ps
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef VRAM_ARB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // VRAM macro: registered read, unwritten locations return a fixed pattern.
  logic [15:0] vram [0:65535];
  bit          vram_ok [0:65535];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 65536; i++) vram_ok[i] <= 1'b0;
    end else if (bus.ram_we) begin
      vram[bus.ram_addr]    <= bus.ram_wdata;
      vram_ok[bus.ram_addr] <= 1'b1;
    end
    if (bus.ram_re)
      bus.ram_rdata <= vram_ok[bus.ram_addr] ? vram[bus.ram_addr] : pattern(bus.ram_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        busy;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
  } vec_t;
  vec_t vecs [10];

  // Random-phase reference model state
  logic [31:0] m_q [$];
  logic [15:0] m_mem [int];
  int          m_starve, m_free_at, m_pop_at, s, s1, s3;
  bit          m_ovf, m_full, m_push;
  bit          e_re [8], e_we [8], e_ack [8];
  logic [15:0] e_addr [8], e_wd [8], e_rd [8];
  logic [15:0] m_last_addr, m_last_wd, m_last_rd, ra;
  int          acks, n_we;
  bit          seen;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : pattern(a);
  endfunction

  function automatic logic [15:0] rnd_addr();
    return 16'(16'h0400 + 16'($urandom_range(0, 15)));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 16'h0011, 16'h00A1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 16'h0012, 16'h00A2, 1'b0, 1'b1, 16'h0010, 16'h00A0};
    vecs[3] = '{1'b1, 16'h0013, 16'h00A3, 1'b0, 1'b0, 16'h0010, 16'h00A0};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0011, 16'h00A1};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0011, 16'h00A1};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0012, 16'h00A2};
    vecs[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0012, 16'h00A2};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0013, 16'h00A3};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0013, 16'h00A3};

    // Reset state
    do_reset();
    chk("reset ram_re", 32'(bus.ram_re), 32'(0));
    chk("reset ram_we", 32'(bus.ram_we), 32'(0));
    chk("reset ram_addr", 32'(bus.ram_addr), 32'(0));
    chk("reset vga_ack", 32'(bus.vga_ack), 32'(0));
    chk("reset vga_rdata", 32'(bus.vga_rdata), 32'(0));
    chk("reset cpu_busy", 32'(bus.cpu_busy), 32'(0));
    chk("reset ovf", 32'(bus.ovf), 32'(0));

    // Write burst with vga_req low; row 2 pushes during the WR pop cycle
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d cpu_busy", i), 32'(bus.cpu_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d ram_we", i), 32'(bus.ram_we), 32'(vecs[i].ram_we));
      chk($sformatf("vec%0d ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].ram_addr));
      chk($sformatf("vec%0d ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].ram_wdata));
      if (bus.ram_we) $display("vec%0d: ram write addr=%h data=%h", i, bus.ram_addr, bus.ram_wdata);
      bus.cpu_we = vecs[i].we; bus.cpu_addr = vecs[i].addr; bus.cpu_wdata = vecs[i].data;
      tick();
    end
    bus.cpu_we = 1'b0;

    // Reset in the middle of a read
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0040;
    tick();
    chk("midrd ram_re", 32'(bus.ram_re), 32'(1));
    chk("midrd ram_addr", 32'(bus.ram_addr), 32'h0040);
    tick();
    rst = 1'b0;
    #1;
    chk("midrd rst ram_re", 32'(bus.ram_re), 32'(0));
    chk("midrd rst ram_addr", 32'(bus.ram_addr), 32'(0));
    chk("midrd rst ram_wdata", 32'(bus.ram_wdata), 32'(0));
    chk("midrd rst vga_rdata", 32'(bus.vga_rdata), 32'(0));
    bus.vga_req = 1'b0;
    acks = 0; n_we = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst = 1'b1;
      tick();
      if (bus.vga_ack) acks++;
      if (bus.ram_we) n_we++;
    end
    chk("midrd no ack", 32'(acks), 32'(0));
    chk("midrd fifo empty (no writes)", 32'(n_we), 32'(0));
    $display("reset mid-read: acks=%0d writes=%0d", acks, n_we);

    // Lone VGA read of a location written through the CPU port
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 16'hBEEF;
    tick();
    bus.cpu_we = 1'b0;
    tick();
    tick();
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
    tick();
    chk("lone t+1 ram_re", 32'(bus.ram_re), 32'(1));
    chk("lone t+1 ram_addr", 32'(bus.ram_addr), 32'h0100);
    tick();
    chk("lone t+2 vga_ack", 32'(bus.vga_ack), 32'(0));
    tick();
    chk("lone t+3 vga_ack", 32'(bus.vga_ack), 32'(1));
    chk("lone t+3 vga_rdata", 32'(bus.vga_rdata), 32'hBEEF);
    bus.vga_req = 1'b0;
    tick();
    chk("lone t+4 vga_ack", 32'(bus.vga_ack), 32'(0));
    chk("lone t+4 rdata hold", 32'(bus.vga_rdata), 32'hBEEF);
    $display("lone read: addr=0100 data=%h", bus.vga_rdata);

    // Starvation guard: one queued write, vga_req held
    do_reset();
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 16'h1234;
    tick();
    bus.cpu_we = 1'b0; bus.vga_req = 1'b1; bus.vga_addr = 16'h0300;
    acks = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (bus.vga_ack) acks++;
      if (bus.ram_we) begin
        seen = 1'b1;
        chk("starve write addr", 32'(bus.ram_addr), 32'h0200);
        chk("starve write data", 32'(bus.ram_wdata), 32'h1234);
      end
    end
    chk("starve write seen", 32'(seen), 32'(1));
    chk("starve acks before write", 32'(acks), 32'(LIMIT));
    $display("starvation: %0d acks then forced write", acks);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (bus.vga_ack) seen = 1'b1;
    end
    chk("starve reads resume", 32'(seen), 32'(1));
    bus.vga_req = 1'b0;

    // Overflow: five strobes while reads hold the RAM
    do_reset();
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0050;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("ovf busy at 5th strobe", 32'(bus.cpu_busy), 32'(1));
      bus.cpu_we = 1'b1; bus.cpu_addr = 16'(16'h0060 + i); bus.cpu_wdata = 16'(16'hC000 + i);
      tick();
    end
    bus.cpu_we = 1'b0;
    chk("ovf flag set", 32'(bus.ovf), 32'(OVF_EN));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.vga_ack) seen = 1'b1;
      else tick();
    end
    chk("ovf read ack", 32'(seen), 32'(1));
    bus.vga_req = 1'b0;
    n_we = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.ram_we) begin
        chk($sformatf("ovf write%0d addr", n_we), 32'(bus.ram_addr), 32'(16'h0060 + n_we));
        $display("ovf drain: write addr=%h data=%h", bus.ram_addr, bus.ram_wdata);
        n_we++;
      end
    end
    chk("ovf write count", 32'(n_we), 32'(4));
    chk("ovf sticky", 32'(bus.ovf), 32'(OVF_EN));
    chk("ovf busy cleared", 32'(bus.cpu_busy), 32'(0));
    do_reset();
    chk("ovf cleared by reset", 32'(bus.ovf), 32'(0));

    // Randomized run against a transaction-scheduling model
    m_q.delete(); m_mem.delete();
    m_starve = 0; m_free_at = 0; m_pop_at = -1; m_ovf = 1'b0;
    m_last_addr = '0; m_last_wd = '0; m_last_rd = '0;
    for (int i = 0; i < 8; i++) begin e_re[i] = 0; e_we[i] = 0; e_ack[i] = 0; end
    for (int k = 0; k < 800; k++) begin
      s = k % 8; s1 = (k + 1) % 8; s3 = (k + 3) % 8;
      if (e_re[s] || e_we[s]) m_last_addr = e_addr[s];
      if (e_we[s]) m_last_wd = e_wd[s];
      if (e_ack[s]) m_last_rd = e_rd[s];
      chk("rnd ram_re", 32'(bus.ram_re), 32'(e_re[s]));
      chk("rnd ram_we", 32'(bus.ram_we), 32'(e_we[s]));
      chk("rnd ram_addr", 32'(bus.ram_addr), 32'(m_last_addr));
      chk("rnd ram_wdata", 32'(bus.ram_wdata), 32'(m_last_wd));
      chk("rnd vga_ack", 32'(bus.vga_ack), 32'(e_ack[s]));
      chk("rnd vga_rdata", 32'(bus.vga_rdata), 32'(m_last_rd));
      chk("rnd cpu_busy", 32'(bus.cpu_busy), 32'(m_q.size() == DEPTH));
      chk("rnd ovf", 32'(bus.ovf), 32'(OVF_EN && m_ovf));
      if (e_we[s]) $display("rnd cycle %0d: write addr=%h data=%h", k, bus.ram_addr, bus.ram_wdata);
      if (e_ack[s]) $display("rnd cycle %0d: read data=%h", k, bus.vga_rdata);
      e_re[s] = 0; e_we[s] = 0; e_ack[s] = 0;

      // Drive: VGA keeps its request until acked, then drops or re-presents
      if (bus.vga_req && bus.vga_ack) begin
        if ($urandom_range(0, 1) == 0) bus.vga_req = 1'b0;
        else bus.vga_addr = rnd_addr();
      end else if (!bus.vga_req && $urandom_range(0, 2) == 0) begin
        bus.vga_req = 1'b1; bus.vga_addr = rnd_addr();
      end
      bus.cpu_we = ($urandom_range(0, 2) == 0) && (!bus.cpu_busy || $urandom_range(0, 5) == 0);
      bus.cpu_addr = rnd_addr(); bus.cpu_wdata = 16'($urandom);

      // Model: a waiting write wins if reads have had their quota or nobody reads
      m_full = (m_q.size() == DEPTH);
      m_push = bus.cpu_we && !m_full;
      if (bus.cpu_we && m_full) m_ovf = 1'b1;
      if (m_q.size() == 0) m_starve = 0;
      if (k >= m_free_at) begin
        if (m_q.size() > 0 && (m_starve == LIMIT || !bus.vga_req)) begin
          e_we[s1] = 1; e_addr[s1] = m_q[0][31:16]; e_wd[s1] = m_q[0][15:0];
          m_mem[int'(m_q[0][31:16])] = m_q[0][15:0];
          m_pop_at = k + 1; m_free_at = k + 2; m_starve = 0;
        end else if (bus.vga_req) begin
          ra = bus.vga_addr;
          e_re[s1] = 1; e_addr[s1] = ra;
          e_ack[s3] = 1; e_rd[s3] = m_read(ra);
          m_free_at = k + 3;
          if (m_q.size() > 0 && m_starve < LIMIT) m_starve++;
        end
      end
      if (m_pop_at == k) void'(m_q.pop_front());
      if (m_push) m_q.push_back({bus.cpu_addr, bus.cpu_wdata});
      tick();
    end
    bus.cpu_we = 1'b0; bus.vga_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
